// File: rtl/hiz_pkg.sv
// rtl/hiz_pkg.sv - shared types and constants for the hierarchical-Z tile array
package hiz_pkg;

  typedef enum logic [1:0] {
    HIZ_LESS   = 2'd0,
    HIZ_LEQUAL = 2'd1,
    HIZ_ALWAYS = 2'd2,
    HIZ_NEVER  = 2'd3
  } hiz_func_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } hiz_state_e;

  // Farthest representable depth for a given width (all ones), valid up to 64 bits.
  function automatic logic [63:0] far_depth(input int unsigned bits);
    return {64{1'b1}} >> (64 - bits);
  endfunction

endpackage

// File: rtl/hiz_compare.sv
// rtl/hiz_compare.sv - coarse depth test of one fragment against one tile bound
// Purely combinational; trivial is forced low when ZMIN_EN is clear.
module hiz_compare
  import hiz_pkg::*;
#(
  parameter int DEPTH_BITS = 24,
  parameter bit ZMIN_EN    = 1'b0
) (
  input  hiz_func_e             func,
  input  logic [DEPTH_BITS-1:0] z,
  input  logic [DEPTH_BITS-1:0] zmax,
  input  logic [DEPTH_BITS-1:0] zmin,
  output logic                  reject,
  output logic                  trivial
);

  logic triv_raw;

  always_comb begin
    reject   = 1'b0;
    triv_raw = 1'b0;
    case (func)
      HIZ_LESS: begin
        reject   = (z >= zmax);
        triv_raw = (z < zmin);
      end
      HIZ_LEQUAL: begin
        reject   = (z > zmax);
        triv_raw = (z <= zmin);
      end
      HIZ_ALWAYS: begin
        reject   = 1'b0;
        triv_raw = 1'b1;
      end
      default: begin
        reject   = 1'b1;
        triv_raw = 1'b0;
      end
    endcase
  end

  // An inconsistent tile (zmin above zmax) lets reject win so the two outputs stay exclusive.
  assign trivial = ZMIN_EN && triv_raw && !reject;

endmodule

// File: rtl/hiz_tile_array.sv
// rtl/hiz_tile_array.sv - per-tile hierarchical-Z bound store with query, update and sweeping clear
// Optional per-tile zmin storage and trivial-accept output under macro HIZ_ZMIN_EN.
module hiz_tile_array
  import hiz_pkg::*;
#(
  parameter int DEPTH_BITS = 24,
  parameter int NUM_TILES  = 64,
  parameter int TILE_IDX_W = $clog2(NUM_TILES),
  parameter int CNT_BITS   = 32
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  q_valid,
  output logic                  q_ready,
  input  logic [TILE_IDX_W-1:0] q_tile,
  input  logic [DEPTH_BITS-1:0] q_z,
  input  logic [1:0]            q_func,
  output logic                  r_valid,
  input  logic                  r_ready,
  output logic                  r_reject,
  output logic                  r_trivial,
  input  logic                  upd_valid,
  output logic                  upd_ready,
  input  logic [TILE_IDX_W-1:0] upd_tile,
  input  logic [DEPTH_BITS-1:0] upd_zmax,
  input  logic [DEPTH_BITS-1:0] upd_zmin,
  input  logic                  clr_start,
  input  logic [DEPTH_BITS-1:0] clr_value,
  output logic                  busy,
  output logic [CNT_BITS-1:0]   reject_cnt
);

  localparam logic [DEPTH_BITS-1:0] FAR      = DEPTH_BITS'(far_depth(DEPTH_BITS));
  localparam logic [TILE_IDX_W-1:0] LAST_IDX = TILE_IDX_W'(NUM_TILES - 1);

  hiz_state_e            state_q, state_d;
  logic [TILE_IDX_W-1:0] clr_idx_q;
  logic [DEPTH_BITS-1:0] clr_val_q;
  logic                  clr_we;
  logic                  q_fire, upd_fire, fwd;
  logic [DEPTH_BITS-1:0] zmax_mem [NUM_TILES];
  logic [DEPTH_BITS-1:0] zmax_eff, zmin_eff;
  logic                  cmp_reject, cmp_trivial;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (clr_start) state_d = ST_CLEAR;
      ST_CLEAR: if (clr_idx_q == LAST_IDX) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q == ST_CLEAR);
    clr_we    = (state_q == ST_CLEAR);
    upd_ready = (state_q == ST_IDLE);
    q_ready   = (state_q == ST_IDLE) && (!r_valid || r_ready);
  end

  assign q_fire   = q_valid && q_ready;
  assign upd_fire = upd_valid && upd_ready;
  assign fwd      = upd_fire && (upd_tile == q_tile);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      clr_idx_q <= '0;
      clr_val_q <= '0;
    end else if (state_q == ST_IDLE && clr_start) begin
      clr_idx_q <= '0;
      clr_val_q <= clr_value;
    end else if (clr_we) begin
      clr_idx_q <= clr_idx_q + TILE_IDX_W'(1);
    end
  end

  // Clear and update never collide: updates are only accepted in IDLE.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NUM_TILES; i++) zmax_mem[i] <= FAR;
    end else if (clr_we) begin
      zmax_mem[clr_idx_q] <= clr_val_q;
    end else if (upd_fire) begin
      zmax_mem[upd_tile] <= upd_zmax;
    end
  end

  assign zmax_eff = fwd ? upd_zmax : zmax_mem[q_tile];

`ifdef HIZ_ZMIN_EN
  localparam bit ZMIN_EN = 1'b1;
  logic [DEPTH_BITS-1:0] zmin_mem [NUM_TILES];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NUM_TILES; i++) zmin_mem[i] <= FAR;
    end else if (clr_we) begin
      zmin_mem[clr_idx_q] <= clr_val_q;
    end else if (upd_fire) begin
      zmin_mem[upd_tile] <= upd_zmin;
    end
  end

  assign zmin_eff = fwd ? upd_zmin : zmin_mem[q_tile];
`else
  localparam bit ZMIN_EN = 1'b0;
  logic unused_zmin;

  assign unused_zmin = ^upd_zmin;
  assign zmin_eff    = FAR;
`endif

  hiz_compare #(
    .DEPTH_BITS (DEPTH_BITS),
    .ZMIN_EN    (ZMIN_EN)
  ) u_compare (
    .func    (hiz_func_e'(q_func)),
    .z       (q_z),
    .zmax    (zmax_eff),
    .zmin    (zmin_eff),
    .reject  (cmp_reject),
    .trivial (cmp_trivial)
  );

  // Result register: a new query may replace the result in the same cycle it is consumed.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_valid   <= 1'b0;
      r_reject  <= 1'b0;
      r_trivial <= 1'b0;
    end else if (q_fire) begin
      r_valid   <= 1'b1;
      r_reject  <= cmp_reject;
      r_trivial <= cmp_trivial;
    end else if (r_ready) begin
      r_valid   <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      reject_cnt <= '0;
    end else if (r_valid && r_ready && r_reject && (reject_cnt != {CNT_BITS{1'b1}})) begin
      reject_cnt <= reject_cnt + CNT_BITS'(1);
    end
  end

endmodule
